// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the two-master RAM port arbiter.
package ram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN0     = 2'd1,
        OWN1     = 2'd2
    } owner_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

endpackage

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: under contention the master not granted last wins.
module ram_port_arbiter_rr_pick2
    import ram_port_arbiter_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  master_e last,
    output logic    gnt0,
    output logic    gnt1
);

    always_comb begin
        gnt0 = req0 & (~req1 | (last == M1));
        gnt1 = req1 & ~gnt0;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between two per-beat req/gnt masters.
// Define ARB_BURST_EN to let an owner hold the port for up to BURST_MAX beats.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    if (BURST_MAX < 1) begin : g_burst_max_chk
        $error("BURST_MAX must be at least 1");
    end

    master_e last_q, last_d;
    owner_e  owner_q, owner_d;
    logic    rvalid0_q, rvalid0_d;
    logic    rvalid1_q, rvalid1_d;
    logic    pick0, pick1;
    logic    gnt0, gnt1;

    ram_port_arbiter_rr_pick2 u_pick (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (last_q),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] beats;

    // An owner still requesting bypasses round-robin until its burst is spent.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (owner_q == OWN0 && m0_req) begin
                gnt0 = 1'b1;
            end else if (owner_q == OWN1 && m1_req) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = pick0;
                gnt1 = pick1;
            end
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
        beats   = CNT_W'(1);
        if (gnt0 || gnt1) begin
            if ((gnt0 && owner_q == OWN0) || (gnt1 && owner_q == OWN1)) begin
                beats = cnt_q + CNT_W'(1);
            end
            if (beats != CNT_W'(BURST_MAX)) begin
                owner_d = gnt0 ? OWN0 : OWN1;
                cnt_d   = beats;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            gnt0 = pick0;
            gnt1 = pick1;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (gnt0) begin
            owner_d = OWN0;
        end else if (gnt1) begin
            owner_d = OWN1;
        end
    end
`endif

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = M0;
        end else if (gnt1) begin
            last_d = M1;
        end
        rvalid0_d = gnt0 & ~m0_we;
        rvalid1_d = gnt1 & ~m1_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= M1;
            owner_q   <= OWN_NONE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            owner_q   <= owner_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    always_comb begin
        m0_gnt    = gnt0;
        m1_gnt    = gnt1;
        ram_en    = gnt0 | gnt1;
        ram_we    = (gnt0 & m0_we) | (gnt1 & m1_we);
        ram_addr  = gnt1 ? m1_addr  : m0_addr;
        ram_din   = gnt1 ? m1_wdata : m0_wdata;
        // Gating by rst discards a read whose data would land during reset.
        m0_rvalid = rvalid0_q & ~rst;
        m1_rvalid = rvalid1_q & ~rst;
        m0_rdata  = ram_dout;
        m1_rdata  = ram_dout;
    end

    a_owner_matches_last: assert property (@(posedge clk) disable iff (rst)
        (owner_q != OWN_NONE) |-> ((owner_q == OWN0) == (last_q == M0)));

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a per-cycle arbitration/memory scoreboard.
module tb_ram_port_arbiter;

    localparam int BURST_MAX = 4;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [15:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_din, ram_dout;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem       [0:65535];
    logic [15:0] model_mem [0:65535];

    ram_port_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port synchronous RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: who must win, what the RAM must see, what read data must return.
    int          last_m  = 1;
    int          hold_m  = -1;
    int          streak  = 0;
    logic        pend0   = 1'b0;
    logic        pend1   = 1'b0;
    logic [15:0] pdata0  = '0;
    logic [15:0] pdata1  = '0;

    always @(negedge clk) begin
        logic eg0, eg1;
        chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, pend0 & ~rst});
        chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, pend1 & ~rst});
        if (pend0 && !rst) chk("m0_rdata", {16'd0, m0_rdata}, {16'd0, pdata0});
        if (pend1 && !rst) chk("m1_rdata", {16'd0, m1_rdata}, {16'd0, pdata1});

        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst) begin
            if (hold_m == 0 && m0_req)            eg0 = 1'b1;
            else if (hold_m == 1 && m1_req)       eg1 = 1'b1;
            else if (m0_req && m1_req)            begin eg0 = (last_m == 1); eg1 = (last_m == 0); end
            else if (m0_req)                      eg0 = 1'b1;
            else if (m1_req)                      eg1 = 1'b1;
        end
        chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, eg0});
        chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, eg1});
        chk("ram_en", {31'd0, ram_en}, {31'd0, eg0 | eg1});
        if (eg0 || eg1) begin
            chk("ram_we",   {31'd0, ram_we},   {31'd0, eg0 ? m0_we : m1_we});
            chk("ram_addr", {16'd0, ram_addr}, {16'd0, eg0 ? m0_addr : m1_addr});
            if (eg0 ? m0_we : m1_we)
                chk("ram_din", {16'd0, ram_din}, {16'd0, eg0 ? m0_wdata : m1_wdata});
        end

        pend0  = eg0 & ~m0_we;
        pend1  = eg1 & ~m1_we;
        pdata0 = model_mem[m0_addr];
        pdata1 = model_mem[m1_addr];
        if (eg0 && m0_we) model_mem[m0_addr] = m0_wdata;
        if (eg1 && m1_we) model_mem[m1_addr] = m1_wdata;

        if (rst) begin
            last_m = 1;
            hold_m = -1;
            streak = 0;
        end else if (eg0 || eg1) begin
            int g;
            g      = eg0 ? 0 : 1;
            last_m = g;
`ifdef ARB_BURST_EN
            streak = (hold_m == g) ? streak + 1 : 1;
            if (streak == BURST_MAX) begin
                hold_m = -1;
                streak = 0;
            end else begin
                hold_m = g;
            end
`endif
        end else begin
            hold_m = -1;
            streak = 0;
        end
    end

    task automatic step(input logic r,
                        input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
        @(posedge clk);
        #1;
        rst = r;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]       = 16'(i) ^ 16'h5A5A;
            model_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        mem[16'h0010]       = 16'hBEEF;
        model_mem[16'h0010] = 16'hBEEF;

        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0020; m0_wdata = '0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0021; m1_wdata = '0;

        // Reset held 3 cycles with both masters requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
            chk("rst_gnt1", {31'd0, m1_gnt}, 32'd0);
            chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
            chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 16'h0021, 16'h0);
        chk("post_rst_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("post_rst_gnt1", {31'd0, m1_gnt}, 32'd0);

        // Solo read by m1
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
        chk("solo_gnt1", {31'd0, m1_gnt}, 32'd1);
        idle();
        chk("solo_rvalid1", {31'd0, m1_rvalid}, 32'd1);
        chk("solo_rdata1", {16'd0, m1_rdata}, 32'h0000BEEF);
        chk("solo_rvalid0", {31'd0, m0_rvalid}, 32'd0);

        // Contention, both reading every cycle
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b1, 1'b0, 16'h0031, 16'h0);
`ifndef ARB_BURST_EN
            chk("alt_gnt0", {31'd0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
`endif
        end
        idle();
        idle();

        // Write then read-back through the other master
        step(1'b0, 1'b1, 1'b1, 16'h0011, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("wr_gnt0", {31'd0, m0_gnt}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0011, 16'h0);
        chk("rd_gnt1", {31'd0, m1_gnt}, 32'd1);
        chk("wr_no_rvalid", {31'd0, m0_rvalid}, 32'd0);
        idle();
        chk("rbw_rvalid1", {31'd0, m1_rvalid}, 32'd1);
        chk("rbw_rdata1", {16'd0, m1_rdata}, 32'h00001234);

`ifdef ARB_BURST_EN
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0);
            chk("burst_gnt0", {31'd0, m0_gnt}, (i < 4 || i >= 8) ? 32'd1 : 32'd0);
        end
        idle();
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0);
        idle();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0043, 16'h0, 1'b1, 1'b0, 16'h0044, 16'h0);
            chk("drop_gnt0", {31'd0, m0_gnt}, 32'd1);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0044, 16'h0);
        chk("drop_gnt1", {31'd0, m1_gnt}, 32'd1);
        idle();
`endif

        // Reset the cycle after a granted read
        step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("mid_gnt0", {31'd0, m0_gnt}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 1'b0, 16'h0051, 16'h0);
        chk("mid_rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);
        chk("mid_rst_en", {31'd0, ram_en}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 1'b0, 16'h0051, 16'h0);
        chk("after_rst_gnt0", {31'd0, m0_gnt}, 32'd1);
        chk("after_rst_rvalid0", {31'd0, m0_rvalid}, 32'd0);

        // Mixed request patterns, scoreboard-checked; requests may drop before grant
        for (int i = 0; i < 24; i++) begin
            logic [4:0] p;
            p = 5'(i * 7 + 3);
            step(1'b0, p[0] | p[3], 1'b0, 16'h0010, 16'h0, p[1] | p[2], 1'b0, 16'h0011, 16'h0);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
